// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared width, M-extension op encoding and issue FSM states
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sign.sv
// ============================================================================
// muldiv_sign : operand sign/magnitude conditioning, divide special cases and
//               result sign fixup around an unsigned iterative core
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH
) (
  input  logic [2:0]              funct3_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [DATA_WIDTH-1:0]   mag_a_o,
  output logic [DATA_WIDTH-1:0]   mag_b_o,
  output logic                    sign_a_o,
  output logic                    sign_b_o,
  output logic                    div_o,
  output logic                    bypass_o,
  output logic [DATA_WIDTH-1:0]   bypass_res_o,
  input  op_e                     fx_op_i,
  input  logic                    fx_sign_a_i,
  input  logic                    fx_sign_b_i,
  input  logic [2*DATA_WIDTH-1:0] prod_i,
  input  logic [DATA_WIDTH-1:0]   quot_i,
  input  logic [DATA_WIDTH-1:0]   rem_i,
  output logic [DATA_WIDTH-1:0]   result_o
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  op_e                    w_op;
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_div_by_zero;
  logic                   w_overflow;
  logic                   w_neg;
  logic [2*DATA_WIDTH-1:0] w_prod_s;
  logic [DATA_WIDTH-1:0]  w_quot_s;
  logic [DATA_WIDTH-1:0]  w_rem_s;

  assign w_op = op_e'(funct3_i);

  always_comb begin
    w_a_signed    = w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    w_b_signed    = w_op inside {OP_MULH, OP_DIV, OP_REM};
    sign_a_o      = w_a_signed & a_i[DATA_WIDTH-1];
    sign_b_o      = w_b_signed & b_i[DATA_WIDTH-1];
    mag_a_o       = sign_a_o ? -a_i : a_i;
    mag_b_o       = sign_b_o ? -b_i : b_i;
    div_o         = funct3_i[2];
    w_div_by_zero = div_o && (b_i == '0);
    w_overflow    = (w_op inside {OP_DIV, OP_REM}) && (a_i == MIN_NEG) && (b_i == ALL_ONES);
    bypass_o      = w_div_by_zero | w_overflow;
    // funct3[1] separates remainder ops from quotient ops among the divides
    bypass_res_o  = '0;
    if (w_div_by_zero) begin
      bypass_res_o = funct3_i[1] ? a_i : ALL_ONES;
    end else if (w_overflow) begin
      bypass_res_o = funct3_i[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    w_neg    = fx_sign_a_i ^ fx_sign_b_i;
    w_prod_s = w_neg ? -prod_i : prod_i;
    w_quot_s = w_neg ? -quot_i : quot_i;
    w_rem_s  = fx_sign_a_i ? -rem_i : rem_i;
    case (fx_op_i)
      OP_MUL:                        result_o = w_prod_s[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_o = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:               result_o = w_quot_s;
      default:                       result_o = w_rem_s;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_issue.sv
// ============================================================================
// muldiv_issue : execute-stage issue/stall controller for M-extension ops,
//                driving an external unsigned multiply/divide core
// Revision     : 1.0
// ============================================================================
`default_nettype none

module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    isMulE,
  input  logic [2:0]              funct3E,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic                    flushE,
  output logic [DATA_WIDTH-1:0]   OUT,
  output logic                    isDone,
  output logic                    stallE,
  output logic                    core_start,
  output logic                    core_div,
  output logic [DATA_WIDTH-1:0]   core_a,
  output logic [DATA_WIDTH-1:0]   core_b,
  output logic                    core_abort,
  input  logic                    core_done,
  input  logic [2*DATA_WIDTH-1:0] core_prod,
  input  logic [DATA_WIDTH-1:0]   core_quot,
  input  logic [DATA_WIDTH-1:0]   core_rem
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic                  sa_q, sa_d, sb_q, sb_d, div_q, div_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;

  logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b, w_bypass_res, w_result;
  logic                  w_sa, w_sb, w_div, w_bypass;

  muldiv_sign #(.DATA_WIDTH(DATA_WIDTH)) u_sign (
    .funct3_i     (funct3E),
    .a_i          (A),
    .b_i          (B),
    .mag_a_o      (w_mag_a),
    .mag_b_o      (w_mag_b),
    .sign_a_o     (w_sa),
    .sign_b_o     (w_sb),
    .div_o        (w_div),
    .bypass_o     (w_bypass),
    .bypass_res_o (w_bypass_res),
    .fx_op_i      (op_q),
    .fx_sign_a_i  (sa_q),
    .fx_sign_b_i  (sb_q),
    .prod_i       (core_prod),
    .quot_i       (core_quot),
    .rem_i        (core_rem),
    .result_o     (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    div_d      = div_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    isDone     = 1'b0;
    stallE     = 1'b0;
    core_start = 1'b0;
    core_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst_n gate keeps stallE low while reset is held with isMulE high
        if (rst_n && isMulE && !flushE) begin
          stallE  = 1'b1;
          op_d    = op_e'(funct3E);
          sa_d    = w_sa;
          sb_d    = w_sb;
          div_d   = w_div;
          a_d     = w_mag_a;
          b_d     = w_mag_b;
          if (w_bypass) begin
            out_d   = w_bypass_res;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        stallE     = 1'b1;
        core_start = 1'b1;
        if (flushE) begin
          core_abort = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        stallE = 1'b1;
        if (flushE) begin
          core_abort = 1'b1;
          state_d    = S_IDLE;
        end else if (core_done) begin
          out_d   = w_result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        isDone  = !flushE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign OUT      = out_q;
  assign core_a   = a_q;
  assign core_b   = b_q;
  assign core_div = div_q;

endmodule

`default_nettype wire
